// File: rtl/npu_dot_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : npu_dot_ctrl
// Description : Dot-product sequencer for one INT8 MAC unit. Accepts a
//               command (length, A/B base addresses), streams operand pairs
//               from two 1-cycle-latency SRAMs into the MAC and returns the
//               32-bit accumulator over a valid/ready result port.
//               Optional feature macro: NPU_DOT_RELU_EN (ReLU on result).
// Revision    : 1.0 - initial release
// ============================================================================
module npu_dot_ctrl #(
  parameter int ADDR_W = 12,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [LEN_W-1:0]  i_cmd_len,
  input  logic [ADDR_W-1:0] i_cmd_a_base,
  input  logic [ADDR_W-1:0] i_cmd_b_base,
  output logic              o_sram_a_rd_en,
  output logic [ADDR_W-1:0] o_sram_a_addr,
  input  logic [7:0]        i_sram_a_rdata,
  output logic              o_sram_b_rd_en,
  output logic [ADDR_W-1:0] o_sram_b_addr,
  input  logic [7:0]        i_sram_b_rdata,
  output logic [7:0]        o_mac_a,
  output logic [7:0]        o_mac_b,
  output logic              o_mac_clear,
  input  logic [31:0]       i_mac_acc,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic [31:0]       o_res_data,
  output logic              o_busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_cmd_ready;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]  r_a_addr;
  logic [ADDR_W-1:0]  r_b_addr;
  logic               r_drain;
  logic               r_rd_v;
  logic [7:0]         r_mac_a;
  logic [7:0]         r_mac_b;

  logic               w_accept;
  logic               w_rd_en;
  logic               w_clear;
  logic               w_res_valid;
  logic               w_last;
  logic [31:0]        w_res;

  // Issue index reaching len-1 marks the final read of the command.
  assign w_last = ((r_cnt + LEN_W'(1)) == r_len);

`ifdef NPU_DOT_RELU_EN
  assign w_res = i_mac_acc[31] ? 32'd0 : i_mac_acc;
`else
  assign w_res = i_mac_acc;
`endif

  // State register; reset aborts any command and discards in-flight reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and per-state strobes.
  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_rd_en     = 1'b0;
    w_clear     = 1'b0;
    w_res_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_accept = i_cmd_valid && r_cmd_ready;
        if (w_accept) w_next = S_CLEAR;
      end
      S_CLEAR: begin
        w_clear = 1'b1;
        w_next  = (r_len == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        w_rd_en = 1'b1;
        if (w_last) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_drain) w_next = S_DONE;
      end
      S_DONE: begin
        w_res_valid = 1'b1;
        if (i_res_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Registered cmd_ready: low during reset, high from the first cycle in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_ready <= 1'b0;
    end else begin
      r_cmd_ready <= (w_next == S_IDLE);
    end
  end

  // Command latch, address walk (wraps naturally) and issue counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len    <= '0;
      r_cnt    <= '0;
      r_a_addr <= '0;
      r_b_addr <= '0;
    end else if (w_accept) begin
      r_len    <= i_cmd_len;
      r_cnt    <= '0;
      r_a_addr <= i_cmd_a_base;
      r_b_addr <= i_cmd_b_base;
    end else if (w_rd_en) begin
      r_cnt    <= r_cnt + LEN_W'(1);
      r_a_addr <= r_a_addr + ADDR_W'(1);
      r_b_addr <= r_b_addr + ADDR_W'(1);
    end
  end

  // Two-cycle drain timer: toggles only while in DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drain <= 1'b0;
    end else begin
      r_drain <= (r_state == S_DRAIN) ? ~r_drain : 1'b0;
    end
  end

  // Operand pipeline: a read issued at T gives data at T+1; the operand
  // register presents it during T+2, and is zero otherwise so acc holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_v  <= 1'b0;
      r_mac_a <= '0;
      r_mac_b <= '0;
    end else begin
      r_rd_v  <= w_rd_en;
      r_mac_a <= r_rd_v ? i_sram_a_rdata : 8'd0;
      r_mac_b <= r_rd_v ? i_sram_b_rdata : 8'd0;
    end
  end

  assign o_cmd_ready    = r_cmd_ready;
  assign o_sram_a_rd_en = w_rd_en;
  assign o_sram_b_rd_en = w_rd_en;
  assign o_sram_a_addr  = w_rd_en ? r_a_addr : '0;
  assign o_sram_b_addr  = w_rd_en ? r_b_addr : '0;
  assign o_mac_a        = r_mac_a;
  assign o_mac_b        = r_mac_b;
  assign o_mac_clear    = w_clear;
  assign o_res_valid    = w_res_valid;
  assign o_res_data     = w_res_valid ? w_res : 32'd0;
  assign o_busy         = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_npu_dot_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_npu_dot_ctrl
// Description : Self-checking bench for npu_dot_ctrl with SRAM and MAC models
//               and a result/address scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_npu_dot_ctrl;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               i_cmd_valid;
  logic               o_cmd_ready;
  logic [15:0]        i_cmd_len;
  logic [11:0]        i_cmd_a_base;
  logic [11:0]        i_cmd_b_base;
  logic               o_sram_a_rd_en;
  logic [11:0]        o_sram_a_addr;
  logic [7:0]         i_sram_a_rdata;
  logic               o_sram_b_rd_en;
  logic [11:0]        o_sram_b_addr;
  logic [7:0]         i_sram_b_rdata;
  logic signed [7:0]  o_mac_a;
  logic signed [7:0]  o_mac_b;
  logic               o_mac_clear;
  logic signed [31:0] r_acc;
  logic               o_res_valid;
  logic               i_res_ready;
  logic [31:0]        o_res_data;
  logic               o_busy;

  logic signed [7:0]  mem_a [4096];
  logic signed [7:0]  mem_b [4096];
  logic [11:0]        aq[$];
  logic [11:0]        bq[$];
  logic [31:0]        sbq[$];
  int                 cyc = 0;
  int                 total = 0;
  int                 bad = 0;

  npu_dot_ctrl #(.ADDR_W(12), .LEN_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_len(i_cmd_len), .i_cmd_a_base(i_cmd_a_base), .i_cmd_b_base(i_cmd_b_base),
    .o_sram_a_rd_en(o_sram_a_rd_en), .o_sram_a_addr(o_sram_a_addr), .i_sram_a_rdata(i_sram_a_rdata),
    .o_sram_b_rd_en(o_sram_b_rd_en), .o_sram_b_addr(o_sram_b_addr), .i_sram_b_rdata(i_sram_b_rdata),
    .o_mac_a(o_mac_a), .o_mac_b(o_mac_b), .o_mac_clear(o_mac_clear), .i_mac_acc(r_acc),
    .o_res_valid(o_res_valid), .i_res_ready(i_res_ready), .o_res_data(o_res_data), .o_busy(o_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Single-port SRAMs with one-cycle read latency.
  always @(posedge clk) begin
    if (o_sram_a_rd_en) i_sram_a_rdata <= mem_a[o_sram_a_addr];
    if (o_sram_b_rd_en) i_sram_b_rdata <= mem_b[o_sram_b_addr];
  end

  // MAC: accumulates every uncleared cycle, shares rst_n.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_acc <= 32'sd0;
    else if (o_mac_clear) r_acc <= 32'sd0;
    else                  r_acc <= r_acc + o_mac_a * o_mac_b;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Read-address scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n && (o_sram_a_rd_en || o_sram_b_rd_en)) begin
      chk("rd_en_pair", {31'd0, o_sram_b_rd_en}, {31'd0, o_sram_a_rd_en});
      if (aq.size() == 0) begin
        chk("unexpected_read", 32'd1, 32'd0);
      end else begin
        chk("addr_a", {20'd0, o_sram_a_addr}, {20'd0, aq.pop_front()});
        chk("addr_b", {20'd0, o_sram_b_addr}, {20'd0, bq.pop_front()});
      end
    end
  end

  function automatic logic [31:0] model_dot(input int len, input int ab, input int bb);
    int s = 0;
    for (int i = 0; i < len; i++)
      s += int'(mem_a[(ab + i) % 4096]) * int'(mem_b[(bb + i) % 4096]);
`ifdef NPU_DOT_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  task automatic issue(input int len, input int ab, input int bb, input logic [31:0] exp,
                       output int c);
    int n = 0;
    i_cmd_valid  = 1'b1;
    i_cmd_len    = 16'(len);
    i_cmd_a_base = 12'(ab);
    i_cmd_b_base = 12'(bb);
    while (!o_cmd_ready && n < 60) begin
      @(posedge clk); #1; n++;
    end
    chk("cmd_accept", {31'd0, o_cmd_ready}, 32'd1);
    c = cyc;
    for (int i = 0; i < len; i++) begin
      aq.push_back(12'(ab + i));
      bq.push_back(12'(bb + i));
    end
    sbq.push_back(exp);
    @(posedge clk); #1;
    i_cmd_valid = 1'b0;
    chk("busy_after_accept", {31'd0, o_busy}, 32'd1);
  endtask

  task automatic wait_res(input int c, input int len, input int hold);
    int n = 0;
    logic [31:0] exp;
    logic [31:0] acc0;
    while (!o_res_valid && n < len + 30) begin
      @(posedge clk); #1; n++;
    end
    chk("res_valid_seen", {31'd0, o_res_valid}, 32'd1);
    chk("latency", 32'(cyc - c), (len == 0) ? 32'd2 : 32'(len + 4));
    exp  = (sbq.size() != 0) ? sbq[0] : 32'hDEAD_BEEF;
    acc0 = r_acc;
    for (int i = 0; i < hold; i++) begin
      chk("hold_data", o_res_data, exp);
      chk("hold_valid", {31'd0, o_res_valid}, 32'd1);
      chk("hold_ops_zero", {16'd0, o_mac_a, o_mac_b}, 32'd0);
      chk("hold_cmd_ready", {31'd0, o_cmd_ready}, 32'd0);
      @(posedge clk); #1;
    end
    chk("acc_stable", r_acc, acc0);
    i_res_ready = 1'b1;
    chk("res_data", o_res_data, (sbq.size() != 0) ? sbq.pop_front() : 32'hDEAD_BEEF);
    @(posedge clk); #1;
    i_res_ready = 1'b0;
    chk("idle_after", {31'd0, o_busy}, 32'd0);
    chk("ready_after", {31'd0, o_cmd_ready}, 32'd1);
  endtask

  initial begin
    int c;
    int hc;
    logic seen;
    for (int i = 0; i < 4096; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    rst_n = 1'b0; i_cmd_valid = 1'b1; i_cmd_len = 16'd3;
    i_cmd_a_base = 12'h5; i_cmd_b_base = 12'h6; i_res_ready = 1'b0;

    // 1: reset with cmd_valid high
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", {31'd0, o_cmd_ready}, 32'd0);
    chk("rst_outs", {o_busy, o_sram_a_rd_en, o_sram_b_rd_en, o_mac_clear, o_res_valid},
        32'd0);
    chk("rst_data", o_res_data | {8'd0, o_sram_a_addr, o_sram_b_addr} | {16'd0, o_mac_a, o_mac_b},
        32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", {31'd0, o_cmd_ready}, 32'd1);
    i_cmd_valid = 1'b0;
    @(posedge clk); #1;

    // 2: basic dot product
    for (int i = 0; i < 4; i++) begin
      mem_a[12'h010 + i] = 8'(i + 1);
      mem_b[12'h020 + i] = 8'(i + 5);
    end
    issue(4, 12'h010, 12'h020, 32'd70, c);
    wait_res(c, 4, 0);

    // 3: zero length
    issue(0, 12'h123, 12'h456, 32'd0, c);
    wait_res(c, 0, 0);

    // 4: signed extremes and negative result
    mem_a[12'h030] = -8'sd128; mem_a[12'h031] = -8'sd128;
    mem_b[12'h040] = -8'sd128; mem_b[12'h041] = 8'sd127;
    issue(2, 12'h030, 12'h040, 32'd128, c);
    wait_res(c, 2, 0);
    mem_a[12'h050] = -8'sd3; mem_b[12'h060] = 8'sd5;
`ifdef NPU_DOT_RELU_EN
    issue(1, 12'h050, 12'h060, 32'd0, c);
`else
    issue(1, 12'h050, 12'h060, 32'hFFFF_FFF1, c);
`endif
    wait_res(c, 1, 0);

    // 5: address wrap
    mem_a[12'hFFE] = 8'sd10;  mem_a[12'hFFF] = -8'sd20;
    mem_a[12'h000] = 8'sd30;  mem_a[12'h001] = -8'sd40;
    for (int i = 0; i < 4; i++) mem_b[12'h100 + i] = 8'(i + 1);
`ifdef NPU_DOT_RELU_EN
    issue(4, 12'hFFE, 12'h100, 32'd0, c);
`else
    issue(4, 12'hFFE, 12'h100, 32'hFFFF_FF9C, c);
`endif
    wait_res(c, 4, 0);

    // random data, longer command
    for (int i = 0; i < 20; i++) begin
      mem_a[12'h200 + i] = 8'($urandom_range(0, 255));
      mem_b[12'h300 + i] = 8'($urandom_range(0, 255));
    end
    issue(20, 12'h200, 12'h300, model_dot(20, 12'h200, 12'h300), c);
    wait_res(c, 20, 0);

    // 6: back-pressure with a deferred command, then reset mid-RUN
    for (int i = 0; i < 3; i++) begin
      mem_a[12'h070 + i] = 8'(i + 1);
      mem_b[12'h080 + i] = 8'(i + 4);
    end
    mem_a[12'h090] = 8'sd7; mem_a[12'h091] = -8'sd8;
    mem_b[12'h0A0] = 8'sd9; mem_b[12'h0A1] = 8'sd10;
    issue(3, 12'h070, 12'h080, 32'd32, c);
    i_cmd_valid = 1'b1; i_cmd_len = 16'd2;
    i_cmd_a_base = 12'h090; i_cmd_b_base = 12'h0A0;
    wait_res(c, 3, 10);
    hc = cyc;
`ifdef NPU_DOT_RELU_EN
    issue(2, 12'h090, 12'h0A0, 32'd0, c);
`else
    issue(2, 12'h090, 12'h0A0, 32'hFFFF_FFEF, c);
`endif
    chk("deferred_accept_cycle", 32'(c - hc), 32'd0);
    wait_res(c, 2, 0);

    issue(8, 12'h200, 12'h300, 32'd0, c);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrun_rd_en", {31'd0, o_sram_a_rd_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    aq.delete(); bq.delete(); sbq.delete();
    chk("midrun_rst_outs", {o_busy, o_sram_a_rd_en, o_res_valid, o_cmd_ready, o_mac_clear},
        32'd0);
    chk("midrun_rst_ops", {16'd0, o_mac_a, o_mac_b}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (o_res_valid || o_busy) seen = 1'b1;
    end
    chk("no_result_after_rst", {31'd0, seen}, 32'd0);
    chk("ready_after_midrun_rst", {31'd0, o_cmd_ready}, 32'd1);
    chk("addr_queue_empty", 32'(aq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
